// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one 8N1 UART transmitter among
//               NUM_REQ (2..4) byte-stream requesters. Forwards one byte per
//               frame and can lock the transmitter to one requester for a
//               multi-byte packet, releasing the lock after HOLD_TIMEOUT idle
//               cycles. All outputs are registered.
// Ports       : tx_clk, rst_n (async, active-low)
//               req_valid/req_data/req_last  : requester byte interface
//               req_ack                      : one-cycle "byte taken" pulse
//               tx_data/tx_start             : to transmitter
//               tx_busy/tx_done              : from transmitter
//               grant_id/locked/err_timeout  : arbitration status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int HOLD_TIMEOUT = 5210
) (
   input  logic                   tx_clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   input  logic                   tx_done,
   output logic [1:0]             grant_id,
   output logic                   locked,
   output logic                   err_timeout
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_DONE = 2'd1,
      S_HOLD      = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           ptr_q, ptr_d;
   logic [15:0]          hold_q, hold_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [7:0]           data_q, data_d;
   logic                 start_q, start_d;
   logic [1:0]           grant_q, grant_d;
   logic                 locked_q, locked_d;
   logic                 err_q, err_d;

   // Requester inputs padded to four entries so 2-bit indices are always legal.
   logic [3:0]           valid_ext;
   logic [3:0]           last_ext;
   logic [7:0]           byte_ext [4];

   always_comb begin
      valid_ext = '0;
      last_ext  = '0;
      for (int i = 0; i < 4; i++) byte_ext[i] = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         valid_ext[i] = req_valid[i];
         last_ext[i]  = req_last[i];
         byte_ext[i]  = req_data[8*i +: 8];
      end
   end

   // Round-robin search starting just after the last owner, wrapping mod NUM_REQ.
   logic       rr_found;
   logic [1:0] rr_winner;
   logic [2:0] rr_idx;

   always_comb begin
      rr_found  = 1'b0;
      rr_winner = '0;
      rr_idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         rr_idx = {1'b0, ptr_q} + 3'(k);
         if (rr_idx >= 3'(NUM_REQ)) rr_idx = rr_idx - 3'(NUM_REQ);
         if (!rr_found && valid_ext[rr_idx[1:0]]) begin
            rr_found  = 1'b1;
            rr_winner = rr_idx[1:0];
         end
      end
   end

   logic       launch_en;
   logic [1:0] launch_id;
   logic [3:0] ack_ext;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      ack_d     = '0;
      start_d   = 1'b0;
      err_d     = 1'b0;
      data_d    = data_q;
      grant_d   = grant_q;
      locked_d  = locked_q;
      launch_en = 1'b0;
      launch_id = '0;
      ack_ext   = '0;

      case (state_q)
         S_IDLE: begin
            if (!tx_busy && rr_found) begin
               launch_en = 1'b1;
               launch_id = rr_winner;
            end
         end
         S_WAIT_DONE: begin
            if (tx_done) begin
               if (locked_q) begin
                  state_d = S_HOLD;
                  hold_d  = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            if (valid_ext[grant_q] && !tx_busy) begin
               launch_en = 1'b1;
               launch_id = grant_q;
               hold_d    = '0;
            end else if (hold_q == 16'(HOLD_TIMEOUT - 1)) begin
               // Forced release; pointer stays on the owner so it ranks last.
               locked_d = 1'b0;
               err_d    = 1'b1;
               state_d  = S_IDLE;
            end else begin
               hold_d = hold_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (launch_en) begin
         ack_ext  = 4'b0001 << launch_id;
         data_d   = byte_ext[launch_id];
         start_d  = 1'b1;
         ack_d    = ack_ext[NUM_REQ-1:0];
         grant_d  = launch_id;
         ptr_d    = launch_id;
         locked_d = ~last_ext[launch_id];
         state_d  = S_WAIT_DONE;
      end
   end

   always_ff @(posedge tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= 2'(NUM_REQ - 1);
         hold_q   <= '0;
         ack_q    <= '0;
         data_q   <= 8'h00;
         start_q  <= 1'b0;
         grant_q  <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         hold_q   <= hold_d;
         ack_q    <= ack_d;
         data_q   <= data_d;
         start_q  <= start_d;
         grant_q  <= grant_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   assign req_ack     = ack_q;
   assign tx_data     = data_q;
   assign tx_start    = start_q;
   assign grant_id    = grant_q;
   assign locked      = locked_q;
   assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed, table-driven bench for uart_tx_arbiter (4 requesters,
//               HOLD_TIMEOUT = 8). The bench plays the transmitter by driving
//               tx_busy/tx_done directly each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int HTO  = 8;

   logic              tx_clk = 1'b0;
   logic              rst_n;
   logic [3:0]        req_valid;
   logic [31:0]       req_data;
   logic [3:0]        req_last;
   logic [3:0]        req_ack;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              tx_busy;
   logic              tx_done;
   logic [1:0]        grant_id;
   logic              locked;
   logic              err_timeout;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(.NUM_REQ(NREQ), .HOLD_TIMEOUT(HTO)) dut (
      .tx_clk      (tx_clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ack     (req_ack),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .grant_id    (grant_id),
      .locked      (locked),
      .err_timeout (err_timeout)
   );

   always #5 tx_clk = ~tx_clk;

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  last;
      logic [31:0] data;
      logic        busy;
      logic        done;
      logic        e_start;
      logic [3:0]  e_ack;
      logic [7:0]  e_data;
      logic [1:0]  e_grant;
      logic        e_locked;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                               input logic b, input logic dn, input logic s, input logic [3:0] a,
                               input logic [7:0] ed, input logic [1:0] g, input logic lk,
                               input logic er);
      vec_t r;
      r.valid = v; r.last = l; r.data = d; r.busy = b; r.done = dn;
      r.e_start = s; r.e_ack = a; r.e_data = ed; r.e_grant = g; r.e_locked = lk; r.e_err = er;
      return r;
   endfunction

   task automatic chk(input string name, input logic s, input logic [3:0] a, input logic [7:0] d,
                      input logic [1:0] g, input logic lk, input logic er);
      checks++;
      if ({tx_start, req_ack, tx_data, grant_id, locked, err_timeout} !== {s, a, d, g, lk, er}) begin
         errors++;
         $display("FAIL %s: got start=%b ack=%b data=%h grant=%0d locked=%b err=%b, expected start=%b ack=%b data=%h grant=%0d locked=%b err=%b",
                  name, tx_start, req_ack, tx_data, grant_id, locked, err_timeout, s, a, d, g, lk, er);
      end
   endtask

   // Drive one cycle's inputs, then sample 1 time unit after the next rising edge.
   task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input logic b, input logic dn);
      req_valid = v; req_last = l; req_data = d; tx_busy = b; tx_done = dn;
      @(posedge tx_clk);
      #1;
   endtask

   localparam logic [31:0] D  = 32'hA3A2A1A0;
   localparam logic [31:0] P2 = 32'hA3B1A1A0;
   localparam logic [31:0] P3 = 32'hA3B2A1A0;

   initial begin
      // Round robin, all four requesting single bytes (pointer starts at 3).
      vecs.push_back(mk(4'hF, 4'hF, D, 0, 0, 1, 4'b0001, 8'hA0, 2'd0, 0, 0));
      vecs.push_back(mk(4'hF, 4'hF, D, 0, 0, 0, 4'b0000, 8'hA0, 2'd0, 0, 0));
      vecs.push_back(mk(4'hF, 4'hF, D, 0, 1, 0, 4'b0000, 8'hA0, 2'd0, 0, 0));
      vecs.push_back(mk(4'hF, 4'hF, D, 0, 0, 1, 4'b0010, 8'hA1, 2'd1, 0, 0));
      vecs.push_back(mk(4'hF, 4'hF, D, 0, 1, 0, 4'b0000, 8'hA1, 2'd1, 0, 0));
      vecs.push_back(mk(4'hF, 4'hF, D, 0, 0, 1, 4'b0100, 8'hA2, 2'd2, 0, 0));
      vecs.push_back(mk(4'hF, 4'hF, D, 0, 1, 0, 4'b0000, 8'hA2, 2'd2, 0, 0));
      vecs.push_back(mk(4'hF, 4'hF, D, 0, 0, 1, 4'b1000, 8'hA3, 2'd3, 0, 0));
      vecs.push_back(mk(4'hF, 4'hF, D, 0, 1, 0, 4'b0000, 8'hA3, 2'd3, 0, 0));
      vecs.push_back(mk(4'hF, 4'hF, D, 0, 0, 1, 4'b0001, 8'hA0, 2'd0, 0, 0));
      vecs.push_back(mk(4'h0, 4'hF, D, 0, 1, 0, 4'b0000, 8'hA0, 2'd0, 0, 0));
      // Packet lock: requester 2 sends 3 bytes while requester 0 waits.
      vecs.push_back(mk(4'b0101, 4'b0001, D,  0, 0, 1, 4'b0100, 8'hA2, 2'd2, 1, 0));
      vecs.push_back(mk(4'b0101, 4'b0001, D,  0, 1, 0, 4'b0000, 8'hA2, 2'd2, 1, 0));
      vecs.push_back(mk(4'b0101, 4'b0001, P2, 0, 0, 1, 4'b0100, 8'hB1, 2'd2, 1, 0));
      vecs.push_back(mk(4'b0101, 4'b0001, P2, 0, 1, 0, 4'b0000, 8'hB1, 2'd2, 1, 0));
      vecs.push_back(mk(4'b0101, 4'b0101, P3, 0, 0, 1, 4'b0100, 8'hB2, 2'd2, 0, 0));
      vecs.push_back(mk(4'b0101, 4'b0101, P3, 0, 1, 0, 4'b0000, 8'hB2, 2'd2, 0, 0));
      vecs.push_back(mk(4'b0001, 4'b0001, D,  0, 0, 1, 4'b0001, 8'hA0, 2'd0, 0, 0));
      vecs.push_back(mk(4'b0000, 4'hF,    D,  0, 1, 0, 4'b0000, 8'hA0, 2'd0, 0, 0));
      // Busy gating in IDLE, then tx_done and a new request in the same cycle.
      vecs.push_back(mk(4'b0010, 4'hF, D, 1, 0, 0, 4'b0000, 8'hA0, 2'd0, 0, 0));
      vecs.push_back(mk(4'b0010, 4'hF, D, 1, 0, 0, 4'b0000, 8'hA0, 2'd0, 0, 0));
      vecs.push_back(mk(4'b0010, 4'hF, D, 0, 0, 1, 4'b0010, 8'hA1, 2'd1, 0, 0));
      vecs.push_back(mk(4'b0011, 4'hF, D, 0, 1, 0, 4'b0000, 8'hA1, 2'd1, 0, 0));
      vecs.push_back(mk(4'b0011, 4'hF, D, 0, 0, 1, 4'b0001, 8'hA0, 2'd0, 0, 0));
      vecs.push_back(mk(4'b0000, 4'hF, D, 0, 1, 0, 4'b0000, 8'hA0, 2'd0, 0, 0));

      rst_n = 1'b0;
      req_valid = '0; req_last = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
      repeat (2) @(posedge tx_clk);
      #1;
      chk("reset_state", 0, 4'b0000, 8'h00, 2'd0, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].busy, vecs[i].done);
         chk($sformatf("vec%0d", i), vecs[i].e_start, vecs[i].e_ack, vecs[i].e_data,
             vecs[i].e_grant, vecs[i].e_locked, vecs[i].e_err);
      end

      // Hold timeout: requester 1 locks, then stops; busy blocks the first HOLD cycles.
      step(4'b0010, 4'b0000, D, 0, 0);
      chk("to_launch", 1, 4'b0010, 8'hA1, 2'd1, 1, 0);
      step(4'b0010, 4'b0000, D, 0, 1);
      chk("to_hold_entry", 0, 4'b0000, 8'hA1, 2'd1, 1, 0);
      for (int i = 0; i < HTO; i++) begin
         if (i < 3) step(4'b0110, 4'b0100, D, 1, 0);
         else       step(4'b0100, 4'b0100, D, 0, 0);
         chk($sformatf("to_hold%0d", i), 0, 4'b0000, 8'hA1, 2'd1, (i != HTO-1), (i == HTO-1));
      end
      step(4'b0100, 4'b0100, D, 0, 0);
      chk("to_next_grant", 1, 4'b0100, 8'hA2, 2'd2, 0, 0);
      step(4'b0000, 4'b0000, D, 0, 1);
      chk("to_after", 0, 4'b0000, 8'hA2, 2'd2, 0, 0);

      // Back-to-back 16-byte packet from requester 3.
      for (int i = 0; i < 16; i++) begin
         logic [7:0] b;
         b = 8'hC0 + 8'(i);
         step(4'b1000, (i == 15) ? 4'b1000 : 4'b0000, {b, 24'h0}, 0, 0);
         chk($sformatf("b2b_launch%0d", i), 1, 4'b1000, b, 2'd3, (i != 15), 0);
         step(4'b0000, 4'b0000, {b, 24'h0}, 0, 1);
         chk($sformatf("b2b_done%0d", i), 0, 4'b0000, b, 2'd3, (i != 15), 0);
      end
      step(4'b0000, 4'b0000, D, 0, 0);
      chk("b2b_idle", 0, 4'b0000, 8'hCF, 2'd3, 0, 0);

      // Reset in the middle of WAIT_DONE.
      step(4'b0010, 4'b1111, D, 0, 0);
      chk("rst_pre_launch", 1, 4'b0010, 8'hA1, 2'd1, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async", 0, 4'b0000, 8'h00, 2'd0, 0, 0);
      @(posedge tx_clk);
      #1;
      chk("rst_held", 0, 4'b0000, 8'h00, 2'd0, 0, 0);
      rst_n = 1'b1;
      step(4'hF, 4'hF, D, 0, 0);
      chk("rst_first_grant", 1, 4'b0001, 8'hA0, 2'd0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
